i2c_master_ctrl: RTL
====================

// Module: i2c_master_ctrl
// PURPOSE
//  Byte-level I2C master sequencer. Driven by the AXI4-Lite slave register file of the i2c IP.
//  Accepts one command at a time (START / WRITE / READ / STOP) over a valid/ready handshake.
//  Sequences SCL/SDA as open-drain pull-low enables and returns read data and ACK status.
//  No clock stretching and no multi-master arbitration.
// PARAMETERS
//  CLK_DIV  250  clock cycles per SCL quarter-phase (100 MHz -> 100 kHz); legal range >= 2
// PORTS
//  s00_axi_aclk     in   1  clock
//  s00_axi_aresetn  in   1  asynchronous active-low reset
//  cmd_valid        in   1  command present
//  cmd_ready        out  1  controller idle, command accepted when cmd_valid & cmd_ready
//  cmd_op           in   2  00 START, 01 WRITE, 10 READ, 11 STOP
//  cmd_last         in   1  READ only: 1 -> NACK the byte, 0 -> ACK it
//  tx_data          in   8  WRITE byte, sent MSB first
//  rx_data          out  8  last byte read
//  rx_valid         out  1  one-cycle pulse when rx_data is updated
//  ack_err          out  1  sticky: NACK received, or WRITE/READ issued with bus idle
//  busy             out  1  command in progress (= ~cmd_ready)
//  bus_active       out  1  set after START, cleared after STOP completes
//  scl_oe           out  1  1 = pull SCL low
//  sda_oe           out  1  1 = pull SDA low
//  sda_i            in   1  sampled SDA line (synchronised outside this block)
// BEHAVIOUR
//  Reset (async, immediate):
//   - scl_oe=0, sda_oe=0, cmd_ready=1, busy=0, bus_active=0.
//   - rx_data=0, rx_valid=0, ack_err=0. FSM -> IDLE, quarter counter and bit counter = 0.
//   - Reset mid-command releases both lines with no further toggling.
//  Handshake:
//   - cmd_op, tx_data and cmd_last are latched on the accepting edge; later changes are ignored.
//   - cmd_ready drops the cycle after acceptance.
//  Timing:
//   - Quarter counter runs 0..CLK_DIV-1. Each quarter (q0..q3) lasts CLK_DIV cycles. One bit = 4 quarters.
//   - Bits per command: START 1, WRITE 9, READ 9, STOP 1.
//   - cmd_ready returns high exactly 4*CLK_DIV*bits cycles after the acceptance edge.
//  FSM: IDLE -> START | WRITE | READ | STOP -> IDLE, on the final q3 tick.
//  START (also used as repeated start):
//   - q0 sda_oe=0 (SCL unchanged); q1 scl_oe=0; q2 sda_oe=1; q3 scl_oe=1.
//   - Sets bus_active and clears ack_err.
//  Data bit (WRITE and READ):
//   - q0: scl_oe=1, drive SDA; q1: scl_oe=0; sample sda_i on the last cycle of q2; q3: scl_oe=1.
//  WRITE:
//   - Bits 0-7: sda_oe = ~tx_data[7-i]. Bit 8: sda_oe=0.
//   - If sda_i=1 is sampled on bit 8, set ack_err.
//  READ:
//   - Bits 0-7: sda_oe=0, shift sda_i into a shift register MSB first. Bit 8: sda_oe = ~cmd_last.
//   - rx_data updates and rx_valid pulses on the completion cycle.
//  STOP:
//   - q0 scl_oe=1, sda_oe=1; q1 scl_oe=0; q2 sda_oe=0; q3 hold. Clear bus_active at the end.
//  Between commands with bus_active=1: SCL is held low (scl_oe=1) and SDA keeps its last value.
//  With bus_active=0: both lines are released.
//  Boundary cases:
//   - WRITE/READ with bus_active=0: no line activity, ack_err set, cmd_ready high the next cycle.
//   - STOP with bus_active=0: no line activity, cmd_ready high the next cycle.
//   - ack_err is cleared only by an accepted START (or by reset).
// TESTING  (all scenarios use CLK_DIV=4)
//  1. START, then WRITE 0xA5 with the slave ACKing -> sda_oe per bit = 0,1,0,1,1,0,1,0 and then 0;
//     ack_err=0; cmd_ready rises 144 cycles after WRITE acceptance.
//  2. WRITE 0x3C with sda_i held 1 -> ack_err=1, held through a STOP, cleared on the next START accept.
//  3. READ cmd_last=0 with the slave driving 0x96 -> rx_data=0x96, rx_valid high for exactly 1 cycle,
//     sda_oe=1 in bit 8. Repeat with cmd_last=1 -> sda_oe=0 in bit 8.
//  4. STOP after a READ -> SDA released while SCL is released; scl_oe=sda_oe=0; bus_active=0;
//     busy=0 after 16 cycles.
//  5. WRITE or STOP issued with the bus idle -> no SCL/SDA toggle; cmd_ready high the next cycle;
//     ack_err=1 for WRITE only.
//  6. s00_axi_aresetn pulled low in bit 4 of a WRITE -> scl_oe=sda_oe=0 and cmd_ready=1 without
//     waiting for a clock edge; after release, a START executes normally.

Source files
------------

// File: rtl/i2c_master_ctrl.sv
// Byte-level I2C master sequencer: executes START / WRITE / READ / STOP commands
// one at a time and drives SCL/SDA as open-drain pull-low enables.
module i2c_master_ctrl #(
    parameter int CLK_DIV = 250
) (
    input  logic       s00_axi_aclk,
    input  logic       s00_axi_aresetn,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic       cmd_last,
    input  logic [7:0] tx_data,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       ack_err,
    output logic       busy,
    output logic       bus_active,
    output logic       scl_oe,
    output logic       sda_oe,
    input  logic       sda_i
);
    localparam int QW = $clog2(CLK_DIV);
    localparam logic [QW-1:0] Q_LAST = QW'(CLK_DIV - 1);

    localparam logic [1:0] OP_START = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_READ  = 2'b10;

    typedef enum logic [2:0] {IDLE, START, WRITE, READ, STOP} state_t;

    state_t          state, state_nx;
    logic [QW-1:0]   q_cnt;
    logic [1:0]      quarter;
    logic [3:0]      bit_cnt;
    logic [3:0]      last_bit;
    logic [7:0]      tx_q;
    logic            last_q;
    logic [7:0]      shift_q;
    logic            sda_hold;
    logic            accept, q_end, cmd_end, sample_tick, data_sda;

    assign cmd_ready   = (state == IDLE);
    assign busy        = ~cmd_ready;
    assign accept      = cmd_valid & cmd_ready;
    assign q_end       = (q_cnt == Q_LAST);
    assign last_bit    = (state == WRITE || state == READ) ? 4'd8 : 4'd0;
    assign cmd_end     = (state != IDLE) && q_end && (quarter == 2'd3) && (bit_cnt == last_bit);
    assign sample_tick = (state == WRITE || state == READ) && q_end && (quarter == 2'd2);

    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) state <= IDLE;
        else                  state <= state_nx;
    end

    // Data-phase commands with no START on the bus never leave IDLE.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    case (cmd_op)
                        OP_START: state_nx = START;
                        OP_WRITE: if (bus_active) state_nx = WRITE;
                        OP_READ:  if (bus_active) state_nx = READ;
                        default:  if (bus_active) state_nx = STOP;
                    endcase
                end
            end
            default: if (cmd_end) state_nx = IDLE;
        endcase
    end

    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            q_cnt   <= '0;
            quarter <= '0;
            bit_cnt <= '0;
        end else if (state == IDLE || cmd_end) begin
            q_cnt   <= '0;
            quarter <= '0;
            bit_cnt <= '0;
        end else begin
            q_cnt <= q_end ? '0 : q_cnt + 1'b1;
            if (q_end) begin
                quarter <= quarter + 2'd1;
                if (quarter == 2'd3) bit_cnt <= bit_cnt + 4'd1;
            end
        end
    end

    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            tx_q       <= '0;
            last_q     <= 1'b0;
            shift_q    <= '0;
            sda_hold   <= 1'b0;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            ack_err    <= 1'b0;
            bus_active <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            if (accept) begin
                tx_q   <= tx_data;
                last_q <= cmd_last;
                if (cmd_op == OP_START)
                    ack_err <= 1'b0;
                else if ((cmd_op == OP_WRITE || cmd_op == OP_READ) && !bus_active)
                    ack_err <= 1'b1;
            end
            if (sample_tick) begin
                if (state == READ && !bit_cnt[3]) shift_q <= {shift_q[6:0], sda_i};
                if (state == WRITE && bit_cnt[3] && sda_i) ack_err <= 1'b1;
            end
            if (state != IDLE) sda_hold <= sda_oe;
            if (cmd_end) begin
                case (state)
                    START: bus_active <= 1'b1;
                    STOP:  bus_active <= 1'b0;
                    READ: begin
                        rx_data  <= shift_q;
                        rx_valid <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    // 7-i for a 3-bit index is its bitwise complement.
    always_comb begin
        data_sda = 1'b0;
        if (state == WRITE) data_sda = bit_cnt[3] ? 1'b0 : ~tx_q[~bit_cnt[2:0]];
        else if (state == READ) data_sda = bit_cnt[3] ? ~last_q : 1'b0;
    end

    always_comb begin
        scl_oe = 1'b0;
        sda_oe = 1'b0;
        case (state)
            IDLE: begin
                scl_oe = bus_active;
                sda_oe = bus_active & sda_hold;
            end
            START: begin
                case (quarter)
                    2'd0: scl_oe = bus_active;
                    2'd1: ;
                    2'd2: sda_oe = 1'b1;
                    default: begin
                        scl_oe = 1'b1;
                        sda_oe = 1'b1;
                    end
                endcase
            end
            WRITE, READ: begin
                scl_oe = (quarter == 2'd0) || (quarter == 2'd3);
                sda_oe = data_sda;
            end
            default: begin
                scl_oe = (quarter == 2'd0);
                sda_oe = (quarter == 2'd0) || (quarter == 2'd1);
            end
        endcase
    end
endmodule
